// File: rtl/led_seq_pkg.sv
// Shared encodings and constants for the LED pattern sequencer.
// Mode encodings, seed patterns, FSM state type and the prescaler width default.
package led_seq_pkg;

    localparam int unsigned DIV_W_DEFAULT = 24;

    localparam logic [1:0] MODE_FLASH = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_PING  = 2'b11;

    localparam logic [7:0] SEED_FLASH = 8'hFF;
    localparam logic [7:0] SEED_LEFT  = 8'h01;
    localparam logic [7:0] SEED_RIGHT = 8'h80;
    localparam logic [7:0] SEED_PING  = 8'h01;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [7:0] seed_for(input logic [1:0] m);
        logic [7:0] s;
        unique case (m)
            MODE_FLASH: s = SEED_FLASH;
            MODE_LEFT:  s = SEED_LEFT;
            MODE_RIGHT: s = SEED_RIGHT;
            default:    s = SEED_PING;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step-rate prescaler: counts up while running and strobes step when the count
// reaches div, restarting from zero so the step period is div+1 cycles.
module led_prescaler
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_hit;

    // >= rather than == so a div shrunk below the current count steps at once
    assign w_hit = (r_cnt >= div);
    assign step  = !clr && w_hit;

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            r_cnt <= '0;
        end else if (clr || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq.sv
// LED pattern sequencer: IDLE/RUN FSM driving flash, rotate and ping-pong
// patterns onto an 8-bit registered LED bus, paced by led_prescaler.
module led_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic [7:0]       q
);

    state_e     r_state, w_state_next;
    logic [7:0] r_q, w_q_next;
    logic       r_tick, w_tick_next;
    logic [1:0] r_mode, w_mode_next;
    logic       r_dir, w_dir_next;
    logic [7:0] w_shift;
    logic       w_clr;
    logic       w_step;

    // Prescaler held at zero in IDLE and on the disabling edge
    assign w_clr = (r_state == IDLE) || !en;

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rs   (rs),
        .clr  (w_clr),
        .div  (div),
        .step (w_step)
    );

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (en)  w_state_next = RUN;
            RUN:     if (!en) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_q_next    = r_q;
        w_tick_next = 1'b0;
        w_mode_next = r_mode;
        w_dir_next  = r_dir;
        w_shift     = r_q;
        if (r_state == IDLE || !en) begin
            w_q_next = 8'h00;
            if (r_state == IDLE && en) begin
                w_q_next    = seed_for(mode);
                w_mode_next = mode;
                w_dir_next  = DIR_LEFT;
            end
        end else if (w_step) begin
            w_tick_next = 1'b1;
            if (mode != r_mode) begin
                w_q_next    = seed_for(mode);
                w_mode_next = mode;
                w_dir_next  = DIR_LEFT;
            end else begin
                unique case (r_mode)
                    MODE_FLASH: w_q_next = ~r_q;
                    MODE_LEFT:  w_q_next = {r_q[6:0], r_q[7]};
                    MODE_RIGHT: w_q_next = {r_q[0], r_q[7:1]};
                    default: begin
                        // Rotate rather than shift so q can never empty out
                        if (r_dir == DIR_LEFT) begin
                            w_shift = {r_q[6:0], r_q[7]};
                            if (w_shift == 8'h80) w_dir_next = DIR_RIGHT;
                        end else begin
                            w_shift = {r_q[0], r_q[7:1]};
                            if (w_shift == 8'h01) w_dir_next = DIR_LEFT;
                        end
                        w_q_next = w_shift;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            r_q    <= 8'h00;
            r_tick <= 1'b0;
            r_mode <= MODE_FLASH;
            r_dir  <= DIR_LEFT;
        end else begin
            r_q    <= w_q_next;
            r_tick <= w_tick_next;
            r_mode <= w_mode_next;
            r_dir  <= w_dir_next;
        end
    end

    always_comb begin
        q    = r_q;
        tick = r_tick;
    end

endmodule

// File: tb/tb_led_seq.sv
// Directed self-checking bench for led_seq: reset, rotate, ping-pong,
// mode change, disable and div-shrink scenarios with hand-computed values.
module tb_led_seq;

    localparam int unsigned DIV_W = 24;

    logic             clk;
    logic             rs;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [7:0]       q;

    int n_checks = 0;
    int n_errors = 0;

    led_seq #(
        .DIV_W (DIV_W)
    ) dut (
        .clk  (clk),
        .rs   (rs),
        .en   (en),
        .mode (mode),
        .div  (div),
        .tick (tick),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Assert reset at a negedge, load inputs, release; returns at k=0 (after seed edge)
    task automatic restart(input logic [1:0] m, input logic [DIV_W-1:0] d);
        rs = 1'b0;
        #1;
        chk("rst_async_q", q, 8'h00);
        chk("rst_async_tick", {7'b0, tick}, 8'h00);
        mode = m;
        div  = d;
        en   = 1'b1;
        cyc(1);
        rs = 1'b1;
        cyc(1);
    endtask

    logic [7:0] pp_exp [16];

    initial begin
        pp_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        // Reset held with en=1: outputs stay cleared
        rs = 1'b0; en = 1'b1; mode = 2'b01; div = 24'd3;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("rst_hold_q", q, 8'h00);
            chk("rst_hold_tick", {7'b0, tick}, 8'h00);
        end
        rs = 1'b1;
        cyc(1);
        chk("rst_release_seed", q, 8'h01);
        chk("rst_release_tick", {7'b0, tick}, 8'h00);

        // Rotate-left, div=2: each value held 3 cycles, wraps back to 0x01
        restart(2'b01, 24'd2);
        for (int k = 0; k <= 26; k++) begin
            chk("rotl_q", q, 8'h01 << ((k / 3) % 8));
            chk("rotl_tick", {7'b0, tick}, {7'b0, (k > 0) && (k % 3 == 0)});
            if (k < 26) cyc(1);
        end

        // Ping-pong, div=0: endpoints shown once per pass
        restart(2'b11, 24'd0);
        for (int k = 0; k < 16; k++) begin
            chk("ping_q", q, pp_exp[k]);
            chk("ping_tick", {7'b0, tick}, {7'b0, k > 0});
            if (k < 15) cyc(1);
        end

        // Flash div=4, then mode change to rotate-right mid-period
        restart(2'b00, 24'd4);
        chk("flash_seed", q, 8'hFF);
        cyc(4);
        chk("flash_hold", q, 8'hFF);
        chk("flash_hold_tick", {7'b0, tick}, 8'h00);
        cyc(1);
        chk("flash_toggle", q, 8'h00);
        chk("flash_toggle_tick", {7'b0, tick}, 8'h01);
        cyc(2);
        mode = 2'b10;
        cyc(2);
        chk("mchg_no_early", q, 8'h00);
        chk("mchg_no_early_tick", {7'b0, tick}, 8'h00);
        cyc(1);
        chk("mchg_seed", q, 8'h80);
        chk("mchg_seed_tick", {7'b0, tick}, 8'h01);
        cyc(5);
        chk("mchg_advance", q, 8'h40);
        chk("mchg_advance_tick", {7'b0, tick}, 8'h01);

        // Disable on a step edge (k=20), re-enable at k=21
        cyc(4);
        en = 1'b0;
        cyc(1);
        chk("dis_q", q, 8'h00);
        chk("dis_tick", {7'b0, tick}, 8'h00);
        en = 1'b1;
        cyc(1);
        chk("reen_seed", q, 8'h80);
        chk("reen_tick", {7'b0, tick}, 8'h00);
        cyc(4);
        chk("reen_hold", q, 8'h80);
        cyc(1);
        chk("reen_advance", q, 8'h40);
        chk("reen_advance_tick", {7'b0, tick}, 8'h01);

        // div shrink: count reaches 7 with div=10, then div=3
        restart(2'b01, 24'd10);
        cyc(7);
        chk("shrink_before", q, 8'h01);
        div = 24'd3;
        cyc(1);
        chk("shrink_step", q, 8'h02);
        chk("shrink_step_tick", {7'b0, tick}, 8'h01);
        cyc(3);
        chk("shrink_hold", q, 8'h02);
        chk("shrink_hold_tick", {7'b0, tick}, 8'h00);
        cyc(1);
        chk("shrink_period", q, 8'h04);
        chk("shrink_period_tick", {7'b0, tick}, 8'h01);

        // Reset mid-RUN one cycle before a step: no tick emerges
        cyc(3);
        rs = 1'b0;
        #1;
        chk("midrun_rst_q", q, 8'h00);
        cyc(1);
        chk("midrun_rst_tick", {7'b0, tick}, 8'h00);
        chk("midrun_rst_hold_q", q, 8'h00);
        rs = 1'b1;
        cyc(1);
        chk("midrun_release_seed", q, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
